vga_sync_gen: RTL and testbench
===============================

Name: vga_sync_gen

Overview:
Pixel-timing generator for the VGA path. It produces the xCount/yCount raster coordinates, hsync/vsync and the display-area qualifier that the drawing blocks (border, paddle, piece animators) read each VGA_clk cycle when they compute red/green/blue. Default timing is 640x480 @ 60 Hz with a 25 MHz VGA_clk. It is the producing end of the coordinate interface that those drawing blocks consume.

Parameters:
H_VISIBLE, 640, active pixels per line
H_FRONT, 16, horizontal front porch in pixels
H_SYNC, 96, hsync pulse width in pixels
H_BACK, 48, horizontal back porch in pixels
V_VISIBLE, 480, active lines per frame
V_FRONT, 10, vertical front porch in lines
V_SYNC, 2, vsync pulse width in lines
V_BACK, 33, vertical back porch in lines
H_POL, 0, hsync active level (0 = active-low)
V_POL, 0, vsync active level (0 = active-low)
CNT_W, 10, coordinate counter width; H_TOTAL and V_TOTAL must each be <= 2^CNT_W

Ports:
VGA_clk  input  1  pixel clock; the only clock
rst_n  input  1  synchronous reset, active-low
en  input  1  pixel advance enable; 1 = advance one pixel this cycle
xCount  output  CNT_W  current horizontal position, 0..H_TOTAL-1
yCount  output  CNT_W  current vertical position, 0..V_TOTAL-1
hsync  output  1  horizontal sync, polarity set by H_POL
vsync  output  1  vertical sync, polarity set by V_POL
displayArea  output  1  1 when xCount < H_VISIBLE and yCount < V_VISIBLE
line_start  output  1  1 while xCount == 0
frame_start  output  1  1 while xCount == 0 and yCount == 0
frameCount  output  8  frame counter (see Optional Feature)

Behaviour:
- Clocking and reset: one clock, VGA_clk. Reset is synchronous and active-low on rst_n, sampled on the VGA_clk rising edge.
- Derived totals: H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK (default 800). V_TOTAL = V_VISIBLE+V_FRONT+V_SYNC+V_BACK (default 525).
- Reset values:
  - xCount = H_TOTAL-1 and yCount = V_TOTAL-1, i.e. the last back-porch pixel.
  - hsync = ~H_POL and vsync = ~V_POL (both inactive).
  - displayArea = 0, line_start = 0, frame_start = 0, frameCount = 0.
  - These values are the same as the decode of position (799,524), so the outputs stay consistent through reset.
- First pixel after reset: the first clock edge with rst_n=1 and en=1 moves to (0,0). In that cycle displayArea=1, line_start=1 and frame_start=1.
- Advance rule (each edge with rst_n=1 and en=1):
  - if xCount < H_TOTAL-1, xCount increments;
  - otherwise xCount becomes 0 and yCount increments, or becomes 0 if yCount == V_TOTAL-1.
- en=0: every output holds its value, including the strobes. Consumers qualify line_start and frame_start with en.
- Registered outputs: every output is a register. Each is computed from the next-state counter values, so all outputs describe the same (xCount,yCount) in the same cycle. There is no cycle skew between the coordinates and the syncs. Latency from position to decode is 0 cycles as seen at the ports.
- hsync is active (level H_POL) exactly when H_VISIBLE+H_FRONT <= xCount < H_VISIBLE+H_FRONT+H_SYNC. Default: x = 656..751.
- vsync is active (level V_POL) exactly when V_VISIBLE+V_FRONT <= yCount < V_VISIBLE+V_FRONT+V_SYNC. Default: y = 490..491, for the whole of each of those lines.
- Comparisons are unsigned at CNT_W bits. Counters never reach H_TOTAL or V_TOTAL.
- Reset asserted mid-frame: on the next edge the block returns to the reset values, regardless of en.
- Reset and en asserted together: reset wins.

Optional Feature:
Macro VGA_SYNC_FRAME_CNT_EN.
- Defined: frameCount increments by 1 on each advance into (0,0), including the first advance after reset. It wraps from 255 to 0 and holds when en=0.
- Undefined: frameCount is tied to 8'd0 and no counter logic is built. The port stays present so the interface does not change.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with en=1 -> xCount=799, yCount=524, hsync=1, vsync=1, displayArea=0, frame_start=0, frameCount=0.
- First pixel: release rst_n with en=1 -> the next edge gives (0,0), displayArea=1, frame_start=1. The edge after that gives (1,0) with frame_start=0.
- Horizontal timing: run one line -> displayArea=1 for x=0..639. hsync=0 for exactly 96 cycles, from x=656 through x=751. x=799 is followed by x=0 with yCount incremented.
- Vertical timing and wrap: run a full frame -> vsync=0 for exactly 1600 cycles, covering y=490..491. (799,524) is followed by (0,0) with frame_start=1. The frame lasts 420000 enabled cycles.
- en stall: deassert en for 5 cycles at x=655 -> all outputs hold. After re-enable the next edge gives x=656 with hsync=0.
- Mid-frame reset and frame counter: pulse rst_n=0 at (300,200) -> outputs match the reset values and the raster restarts at (0,0). With VGA_SYNC_FRAME_CNT_EN defined, frameCount reads 1, then 2 after one more full frame, and wraps to 0 after 256 frames.

Source files
------------

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: coordinates, syncs and display/line/frame qualifiers.
// Optional frame counter enabled by defining VGA_SYNC_FRAME_CNT_EN.
module vga_sync_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter bit H_POL     = 1'b0,
  parameter bit V_POL     = 1'b0,
  parameter int CNT_W     = 10
) (
  input  logic             VGA_clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [CNT_W-1:0] xCount,
  output logic [CNT_W-1:0] yCount,
  output logic             hsync,
  output logic             vsync,
  output logic             displayArea,
  output logic             line_start,
  output logic             frame_start,
  output logic [7:0]       frameCount
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

  // One extra bit so a sync window ending exactly at 2^CNT_W cannot wrap to zero.
  localparam logic [CNT_W:0] H_VIS_E  = (CNT_W+1)'(H_VISIBLE);
  localparam logic [CNT_W:0] V_VIS_E  = (CNT_W+1)'(V_VISIBLE);
  localparam logic [CNT_W:0] HS_START = (CNT_W+1)'(H_VISIBLE + H_FRONT);
  localparam logic [CNT_W:0] HS_END   = (CNT_W+1)'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [CNT_W:0] VS_START = (CNT_W+1)'(V_VISIBLE + V_FRONT);
  localparam logic [CNT_W:0] VS_END   = (CNT_W+1)'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [CNT_W-1:0] r_x;
  logic [CNT_W-1:0] r_y;
  logic             r_hs;
  logic             r_vs;
  logic             r_da;
  logic             r_ls;
  logic             r_fs;
  logic [CNT_W-1:0] w_x_nxt;
  logic [CNT_W-1:0] w_y_nxt;
  logic             w_wrap;

  function automatic logic hs_dec(input logic [CNT_W-1:0] x);
    logic [CNT_W:0] xe;
    xe = {1'b0, x};
    return ((xe >= HS_START) && (xe < HS_END)) ? H_POL : ~H_POL;
  endfunction

  function automatic logic vs_dec(input logic [CNT_W-1:0] y);
    logic [CNT_W:0] ye;
    ye = {1'b0, y};
    return ((ye >= VS_START) && (ye < VS_END)) ? V_POL : ~V_POL;
  endfunction

  function automatic logic da_dec(input logic [CNT_W-1:0] x, input logic [CNT_W-1:0] y);
    return ({1'b0, x} < H_VIS_E) && ({1'b0, y} < V_VIS_E);
  endfunction

  always_comb begin
    w_x_nxt = r_x + CNT_W'(1);
    w_y_nxt = r_y;
    if (r_x == H_LAST) begin
      w_x_nxt = '0;
      w_y_nxt = (r_y == V_LAST) ? '0 : r_y + CNT_W'(1);
    end
  end

  assign w_wrap = (w_x_nxt == '0) && (w_y_nxt == '0);

  // Decode is taken from the next position so every output describes the same pixel.
  always_ff @(posedge VGA_clk) begin
    if (!rst_n) begin
      r_x  <= H_LAST;
      r_y  <= V_LAST;
      r_hs <= ~H_POL;
      r_vs <= ~V_POL;
      r_da <= 1'b0;
      r_ls <= 1'b0;
      r_fs <= 1'b0;
    end else if (en) begin
      r_x  <= w_x_nxt;
      r_y  <= w_y_nxt;
      r_hs <= hs_dec(w_x_nxt);
      r_vs <= vs_dec(w_y_nxt);
      r_da <= da_dec(w_x_nxt, w_y_nxt);
      r_ls <= (w_x_nxt == '0);
      r_fs <= w_wrap;
    end
  end

`ifdef VGA_SYNC_FRAME_CNT_EN
  logic [7:0] r_fc;

  always_ff @(posedge VGA_clk) begin
    if (!rst_n) begin
      r_fc <= 8'd0;
    end else if (en && w_wrap) begin
      r_fc <= r_fc + 8'd1;
    end
  end

  assign frameCount = r_fc;
`else
  assign frameCount = 8'd0;
`endif

  assign xCount      = r_x;
  assign yCount      = r_y;
  assign hsync       = r_hs;
  assign vsync       = r_vs;
  assign displayArea = r_da;
  assign line_start  = r_ls;
  assign frame_start = r_fs;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench for vga_sync_gen on a reduced 18x13 raster (10/2/3/3, 6/2/2/3).
module tb_vga_sync_gen;

  localparam int HV = 10, HF = 2, HS = 3, HB = 3, HT = 18;
  localparam int VV = 6,  VF = 2, VS = 2, VB = 3, VT = 13;
  localparam int CW = 10;

  typedef struct packed {
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          hs;
    logic          vs;
    logic          da;
    logic          ls;
    logic          fs;
    logic [7:0]    fc;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic          en;
  logic [CW-1:0] xCount;
  logic [CW-1:0] yCount;
  logic          hsync;
  logic          vsync;
  logic          displayArea;
  logic          line_start;
  logic          frame_start;
  logic [7:0]    frameCount;

  exp_t q[$];
  int   n_pass = 0;
  int   n_tot  = 0;
  int   mx, my, mfc;
  int   c_da = 0, c_hs = 0, c_vs = 0, c_fs = 0;

  vga_sync_gen #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .H_POL(1'b0), .V_POL(1'b0), .CNT_W(CW)
  ) dut (
    .VGA_clk    (clk),
    .rst_n      (rst_n),
    .en         (en),
    .xCount     (xCount),
    .yCount     (yCount),
    .hsync      (hsync),
    .vsync      (vsync),
    .displayArea(displayArea),
    .line_start (line_start),
    .frame_start(frame_start),
    .frameCount (frameCount)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int req);
    n_tot++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  // Drive one cycle of stimulus and queue the response the raster should show after it.
  task automatic step(input logic r, input logic e);
    exp_t ex;
    @(negedge clk);
    rst_n = r;
    en    = e;
    if (!r) begin
      mx = HT - 1; my = VT - 1; mfc = 0;
    end else if (e) begin
      if (mx == HT - 1) begin
        mx = 0;
        my = (my == VT - 1) ? 0 : my + 1;
      end else begin
        mx = mx + 1;
      end
      if (mx == 0 && my == 0) mfc = (mfc + 1) % 256;
    end
    ex.x  = CW'(mx);
    ex.y  = CW'(my);
    ex.hs = (mx >= HV + HF && mx < HV + HF + HS) ? 1'b0 : 1'b1;
    ex.vs = (my >= VV + VF && my < VV + VF + VS) ? 1'b0 : 1'b1;
    ex.da = (mx < HV && my < VV);
    ex.ls = (mx == 0);
    ex.fs = (mx == 0 && my == 0);
`ifdef VGA_SYNC_FRAME_CNT_EN
    ex.fc = 8'(mfc);
`else
    ex.fc = 8'd0;
`endif
    q.push_back(ex);
    @(posedge clk);
    #2;
  endtask

  initial begin : monitor
    exp_t ex;
    exp_t got;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        ex  = q.pop_front();
        got = {xCount, yCount, hsync, vsync, displayArea, line_start, frame_start, frameCount};
        n_tot++;
        if (got == ex) n_pass++;
        else $display("FAIL raster: got x=%0d y=%0d hs=%0b vs=%0b da=%0b ls=%0b fs=%0b fc=%0d, expected x=%0d y=%0d hs=%0b vs=%0b da=%0b ls=%0b fs=%0b fc=%0d",
                      got.x, got.y, got.hs, got.vs, got.da, got.ls, got.fs, got.fc,
                      ex.x, ex.y, ex.hs, ex.vs, ex.da, ex.ls, ex.fs, ex.fc);
        if (!hsync)     c_hs++;
        if (!vsync)     c_vs++;
        if (displayArea) c_da++;
        if (frame_start) c_fs++;
      end
    end
  end

  initial begin : stimulus
    int s_da, s_hs, s_vs, s_fs;
    int guard;
    rst_n = 1'b0;
    en    = 1'b1;
    mx = HT - 1; my = VT - 1; mfc = 0;

    repeat (3) step(1'b0, 1'b1);
    chk("reset_x", int'(xCount), 17);
    chk("reset_y", int'(yCount), 12);
    chk("reset_hsync", int'(hsync), 1);
    chk("reset_vsync", int'(vsync), 1);
    chk("reset_da", int'(displayArea), 0);
    chk("reset_ls", int'(line_start), 0);
    chk("reset_fs", int'(frame_start), 0);
    chk("reset_fc", int'(frameCount), 0);

    s_da = c_da; s_hs = c_hs; s_vs = c_vs; s_fs = c_fs;
    step(1'b1, 1'b1);
    chk("first_x", int'(xCount), 0);
    chk("first_y", int'(yCount), 0);
    chk("first_da", int'(displayArea), 1);
    chk("first_ls", int'(line_start), 1);
    chk("first_fs", int'(frame_start), 1);
    step(1'b1, 1'b1);
    chk("second_x", int'(xCount), 1);
    chk("second_fs", int'(frame_start), 0);

    repeat (232) step(1'b1, 1'b1);
    chk("frame_end_x", int'(xCount), 17);
    chk("frame_end_y", int'(yCount), 12);
    chk("frame_da_cycles", c_da - s_da, 60);
    chk("frame_hsync_cycles", c_hs - s_hs, 39);
    chk("frame_vsync_cycles", c_vs - s_vs, 36);
    chk("frame_fs_cycles", c_fs - s_fs, 1);

    step(1'b1, 1'b1);
    chk("wrap_x", int'(xCount), 0);
    chk("wrap_y", int'(yCount), 0);
    chk("wrap_fs", int'(frame_start), 1);
`ifdef VGA_SYNC_FRAME_CNT_EN
    chk("wrap_fc", int'(frameCount), 2);
`else
    chk("wrap_fc", int'(frameCount), 0);
`endif

    repeat (17) step(1'b1, 1'b1);
    chk("line_end_x", int'(xCount), 17);
    step(1'b1, 1'b1);
    chk("line_wrap_x", int'(xCount), 0);
    chk("line_wrap_y", int'(yCount), 1);
    chk("line_wrap_ls", int'(line_start), 1);
    chk("line_wrap_fs", int'(frame_start), 0);

    repeat (11) step(1'b1, 1'b1);
    chk("pre_stall_x", int'(xCount), 11);
    chk("pre_stall_hsync", int'(hsync), 1);
    repeat (5) step(1'b1, 1'b0);
    chk("stall_x", int'(xCount), 11);
    chk("stall_hsync", int'(hsync), 1);
    step(1'b1, 1'b1);
    chk("post_stall_x", int'(xCount), 12);
    chk("post_stall_hsync", int'(hsync), 0);

    guard = 0;
    while (!(mx == 5 && my == 3) && guard < HT * VT) begin
      step(1'b1, 1'b1);
      guard++;
    end
    chk("mid_pos_x", int'(xCount), 5);
    chk("mid_pos_y", int'(yCount), 3);
    step(1'b0, 1'b0);
    chk("mid_reset_x", int'(xCount), 17);
    chk("mid_reset_y", int'(yCount), 12);
    chk("mid_reset_hsync", int'(hsync), 1);
    chk("mid_reset_da", int'(displayArea), 0);
    chk("mid_reset_fc", int'(frameCount), 0);
    step(1'b1, 1'b1);
    chk("restart_x", int'(xCount), 0);
    chk("restart_y", int'(yCount), 0);
    chk("restart_fs", int'(frame_start), 1);
`ifdef VGA_SYNC_FRAME_CNT_EN
    chk("restart_fc", int'(frameCount), 1);
    repeat (HT * VT) step(1'b1, 1'b1);
    chk("fc_two", int'(frameCount), 2);
    repeat (254 * HT * VT) step(1'b1, 1'b1);
    chk("fc_wrap", int'(frameCount), 0);
    chk("fc_wrap_fs", int'(frame_start), 1);
`else
    chk("restart_fc", int'(frameCount), 0);
    repeat (HT * VT) step(1'b1, 1'b1);
    chk("fc_tied", int'(frameCount), 0);
    chk("frame2_fs", int'(frame_start), 1);
`endif

    repeat (3) @(posedge clk);
    #3;
    chk("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
